// File: rtl/fmult_seq_if.sv
// Operand, product and handshake bundle for the sequential FMULT.
// master drives START and the operands; slave returns products and status.
interface fmult_seq_if;
  logic        START;
  logic [15:0] A1, A2, B1, B2, B3, B4, B5, B6;
  logic [10:0] SR1, SR2, DQ1, DQ2, DQ3, DQ4, DQ5, DQ6;
  logic [15:0] WA1, WA2, WB1, WB2, WB3, WB4, WB5, WB6;
  logic        BUSY, DONE;

  modport master (
    output START,
    output A1, A2, B1, B2, B3, B4, B5, B6,
    output SR1, SR2, DQ1, DQ2, DQ3, DQ4, DQ5, DQ6,
    input  WA1, WA2, WB1, WB2, WB3, WB4, WB5, WB6,
    input  BUSY, DONE
  );

  modport slave (
    input  START,
    input  A1, A2, B1, B2, B3, B4, B5, B6,
    input  SR1, SR2, DQ1, DQ2, DQ3, DQ4, DQ5, DQ6,
    output WA1, WA2, WB1, WB2, WB3, WB4, WB5, WB6,
    output BUSY, DONE
  );
endinterface

// File: rtl/fmult_seq.sv
// G.721/G.726 FMULT shared across the eight predictor taps.
// One product per cycle: WA1, WA2, WB1..WB6, then a one-cycle DONE.
module fmult_seq (
  input  logic        CLK,
  input  logic        RESET_N,
  fmult_seq_if.slave  bus
);
  localparam int NPROD = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]                  state;
  logic [2:0]                  idx;
  logic [NPROD-1:0][15:0]      coef;
  logic [NPROD-1:0][10:0]      flt;
  logic [NPROD-1:0][15:0]      w;
  logic                        busy;
  logic                        done;
  logic                        accept;
  logic [15:0]                 prod;

  function automatic logic [15:0] fmult(
    input logic [15:0] c,
    input logic [10:0] f
  );
    logic        cs;
    logic [14:0] neg;
    logic [12:0] cmag;
    logic [3:0]  cexp;
    logic [18:0] sh;
    logic [5:0]  cmant;
    logic        ws;
    logic [4:0]  wexp;
    logic [11:0] mp;
    logic [7:0]  wmant;
    logic [16:0] big;
    logic [14:0] wmag;
    cs   = c[15];
    neg  = 15'd16384 - {1'b0, c[15:2]};
    cmag = cs ? neg[12:0] : c[14:2];
    cexp = 4'd0;
    for (int i = 0; i < 13; i++)
      if (cmag[i]) cexp = 4'(i + 1);
    sh    = {cmag, 6'b0} >> cexp;
    cmant = (cmag == 13'd0) ? 6'd32 : sh[5:0];
    ws    = f[10] ^ cs;
    wexp  = {1'b0, f[9:6]} + {1'b0, cexp};
    mp    = {6'b0, f[5:0]} * {6'b0, cmant} + 12'd48;
    wmant = mp[11:4];
    big   = {2'b0, wmant, 7'b0};
    // Exponents past 26 wrap: shift left and keep the low 15 bits
    if (wexp > 5'd26)
      big = big << (wexp - 5'd26);
    else
      big = big >> (5'd26 - wexp);
    wmag = big[14:0];
    fmult = ws ? 16'd0 - {1'b0, wmag} : {1'b0, wmag};
  endfunction

  assign accept = bus.START && (state == IDLE || state == FIN);
  assign prod   = fmult(coef[idx], flt[idx]);

  assign bus.WA1  = w[0];
  assign bus.WA2  = w[1];
  assign bus.WB1  = w[2];
  assign bus.WB2  = w[3];
  assign bus.WB3  = w[4];
  assign bus.WB4  = w[5];
  assign bus.WB5  = w[6];
  assign bus.WB6  = w[7];
  assign bus.BUSY = busy;
  assign bus.DONE = done;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      idx   <= 3'd0;
      coef  <= '0;
      flt   <= '0;
      w     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (accept) begin
        coef <= {bus.B6, bus.B5, bus.B4, bus.B3,
                 bus.B2, bus.B1, bus.A2, bus.A1};
        flt  <= {bus.DQ6, bus.DQ5, bus.DQ4, bus.DQ3,
                 bus.DQ2, bus.DQ1, bus.SR2, bus.SR1};
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            idx   <= 3'd0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          w[idx] <= prod;
          idx    <= idx + 3'd1;
          if (idx == 3'd7) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          done <= 1'b0;
          idx  <= 3'd0;
          if (accept) begin
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmult_seq.sv
// Directed bench for fmult_seq: hand-computed FMULT vectors,
// mid-run reset, output ordering, latching and START handshake.
module tb_fmult_seq;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fmult_seq_if bus ();

  fmult_seq dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ops(input logic [7:0][15:0] c,
                     input logic [7:0][10:0] f);
    bus.A1 = c[0]; bus.A2 = c[1];
    bus.B1 = c[2]; bus.B2 = c[3]; bus.B3 = c[4];
    bus.B4 = c[5]; bus.B5 = c[6]; bus.B6 = c[7];
    bus.SR1 = f[0]; bus.SR2 = f[1];
    bus.DQ1 = f[2]; bus.DQ2 = f[3]; bus.DQ3 = f[4];
    bus.DQ4 = f[5]; bus.DQ5 = f[6]; bus.DQ6 = f[7];
  endtask

  function automatic logic [15:0] wout(input int i);
    case (i)
      0: wout = bus.WA1;
      1: wout = bus.WA2;
      2: wout = bus.WB1;
      3: wout = bus.WB2;
      4: wout = bus.WB3;
      5: wout = bus.WB4;
      6: wout = bus.WB5;
      default: wout = bus.WB6;
    endcase
  endfunction

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!bus.DONE && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", {31'b0, bus.DONE}, 32'd1);
  endtask

  logic [7:0][15:0] c;
  logic [7:0][10:0] f;
  logic [15:0]      exp_v [8];
  logic [15:0]      exp_o [8];
  int n, b, d, at;

  initial begin
    // sign, boundary and wrap vector
    exp_v = '{16'h0430, 16'hFBD0, 16'hFBD0, 16'hFFF8,
              16'h0000, 16'h0000, 16'h0000, 16'h7600};
    // ordering vector: coef 0x4000, exp 6..13, idx 1 and 5 negative
    exp_o = '{16'h0043, 16'hFF7A, 16'h010C, 16'h0218,
              16'h0430, 16'hF7A0, 16'h10C0, 16'h2180};

    rst_n     = 1'b0;
    bus.START = 1'b0;
    c = '0;
    f = '0;
    ops(c, f);
    #12;
    chk("rst_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("rst_done", {31'b0, bus.DONE}, 32'd0);
    chk("rst_wa1", {16'b0, bus.WA1}, 32'd0);
    rst_n = 1'b1;
    step();

    c = '{16'h7FFC, 16'h0000, 16'h0000, 16'hFFFC,
          16'h8000, 16'h4000, 16'hC000, 16'h4000};
    f = '{11'h3FF, 11'h020, 11'h020, 11'h020,
          11'h3FF, 11'h6A0, 11'h2A0, 11'h2A0};
    ops(c, f);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    wait_done(12, n);
    chk("vec_latency", n, 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("vec_w%0d", i), {16'b0, wout(i)}, {16'b0, exp_v[i]});

    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    repeat (4) step();
    chk("mid_wa1", {16'b0, bus.WA1}, 32'h0430);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++)
      chk($sformatf("arst_w%0d", i), {16'b0, wout(i)}, 32'd0);
    chk("arst_busy", {31'b0, bus.BUSY}, 32'd0);
    chk("arst_done", {31'b0, bus.DONE}, 32'd0);
    #2;
    rst_n = 1'b1;
    d = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.DONE) d++;
    end
    chk("arst_no_done", d, 32'd0);

    for (int i = 0; i < 8; i++) begin
      c[i] = 16'h0000;
      f[i] = 11'h020;
    end
    ops(c, f);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    b = bus.BUSY ? 1 : 0;
    d = 0;
    at = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.BUSY) b++;
      if (bus.DONE) begin
        d++;
        at = i;
      end
    end
    chk("zero_busy_cyc", b, 32'd8);
    chk("zero_done_cyc", d, 32'd1);
    chk("zero_done_at", at, 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("zero_w%0d", i), {16'b0, wout(i)}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      c[i] = 16'h4000;
      f[i] = {(i == 1 || i == 5), 4'(6 + i), 6'd32};
    end
    ops(c, f);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c[i] = 16'h7FFC;
      f[i] = 11'h3FF;
    end
    ops(c, f);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("ord_w%0d", i), {16'b0, wout(i)}, {16'b0, exp_o[i]});
      if (i < 7)
        chk($sformatf("ord_hold%0d", i + 1), {16'b0, wout(i + 1)}, 32'd0);
    end
    chk("ord_done", {31'b0, bus.DONE}, 32'd1);
    chk("ord_busy", {31'b0, bus.BUSY}, 32'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ord_fin_w%0d", i), {16'b0, wout(i)}, {16'b0, exp_o[i]});
    step();

    bus.START = 1'b1;
    d = 0;
    at = -1;
    for (int i = 0; i < 27; i++) begin
      step();
      if (bus.DONE) begin
        d++;
        if (at >= 0) chk("b2b_gap", i - at, 32'd9);
        at = i;
      end
    end
    bus.START = 1'b0;
    chk("b2b_dones", d, 32'd3);
    chk("b2b_last", at, 32'd26);
    step();
    chk("b2b_idle", {31'b0, bus.BUSY}, 32'd0);

    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    step();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    d = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.DONE) d++;
    end
    chk("ign_dones", d, 32'd1);
    chk("ign_busy", {31'b0, bus.BUSY}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
